// File: rtl/user_id_programming.sv
// user_id_programming
//   Supplies the 32-bit user project ID on mask_rev.  The ID is a build-time
//   constant that can be patched post-silicon by XOR with a register value.
//   The patch can be frozen by writing LOCK_KEY to the LOCK register.  Once
//   set, the lock is cleared only by wb_rst_i.
//   Optional feature macro: USER_ID_PARITY_EN.  When it is defined, the
//   mask_rev_parity port is added and the parity appears in LOCK bit 1.
module user_id_programming #(
    parameter logic [31:0] USER_PROJECT_ID = 32'h0000_0000,
    parameter logic [31:0] LOCK_KEY        = 32'h4C4F_434B
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [1:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [31:0] mask_rev,
    output logic        locked
`ifdef USER_ID_PARITY_EN
    ,
    output logic        mask_rev_parity
`endif
);

    typedef enum logic [1:0] {
        REG_ID    = 2'd0,
        REG_PATCH = 2'd1,
        REG_LOCK  = 2'd2,
        REG_BASE  = 2'd3
    } reg_addr_e;

    // Declaration-time values make mask_rev valid before any clock or reset.
    logic [31:0] r_patch_q = '0;
    logic        r_lock_q  = 1'b0;

    reg_addr_e   w_wr_sel;
    reg_addr_e   w_rd_sel;
    logic        w_parity;

    assign w_wr_sel = reg_addr_e'(wr_addr);
    assign w_rd_sel = reg_addr_e'(rd_addr);

    // Patch and sticky lock registers.  Reset takes priority over any write.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_patch_q <= '0;
            r_lock_q  <= 1'b0;
        end else if (wr_en) begin
            if ((w_wr_sel == REG_PATCH) && !r_lock_q) begin
                r_patch_q <= wr_data;
            end
            if ((w_wr_sel == REG_LOCK) && (wr_data == LOCK_KEY)) begin
                r_lock_q <= 1'b1;
            end
        end
    end

    assign mask_rev = USER_PROJECT_ID ^ r_patch_q;
    assign locked   = r_lock_q;

`ifdef USER_ID_PARITY_EN
    assign w_parity        = ^mask_rev;
    assign mask_rev_parity = w_parity;
`else
    assign w_parity        = 1'b0;
`endif

    // Combinational read mux showing the current (pre-edge) register state.
    always_comb begin
        rd_data = '0;
        case (w_rd_sel)
            REG_ID:    rd_data = mask_rev;
            REG_PATCH: rd_data = r_patch_q;
            REG_LOCK:  rd_data = {30'b0, w_parity, r_lock_q};
            REG_BASE:  rd_data = USER_PROJECT_ID;
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_user_id_programming.sv
// Scoreboard testbench for user_id_programming.  The stimulus process updates
// a behavioural model and queues the expected outputs.  A monitor running on
// the falling edge pops and compares them.
module tb_user_id_programming;

    localparam logic [31:0] UPI = 32'hA5A5_3C3C;
    localparam logic [31:0] KEY = 32'h4C4F_434B;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] rd_data;
    logic [31:0] mask_rev;
    logic        locked;
    logic        parity;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        int          kind;   // 0 mask_rev, 1 locked, 2 rd_data, 3 parity
        logic [31:0] want;
    } exp_t;

    exp_t q[$];

    // Behavioural model state and the inputs applied in the previous cycle.
    logic [31:0] m_patch = '0;
    logic        m_lock  = 1'b0;
    logic        p_rst = 1'b0, p_we = 1'b0;
    logic [1:0]  p_wa = '0;
    logic [31:0] p_wd = '0;

    user_id_programming #(
        .USER_PROJECT_ID(UPI),
        .LOCK_KEY(KEY)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wr_en(we),
        .wr_addr(wa),
        .wr_data(wd),
        .rd_addr(ra),
        .rd_data(rd_data),
        .mask_rev(mask_rev),
        .locked(locked)
`ifdef USER_ID_PARITY_EN
        ,
        .mask_rev_parity(parity)
`endif
    );

`ifndef USER_ID_PARITY_EN
    assign parity = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model_id();
        return UPI ^ m_patch;
    endfunction

    function automatic logic model_par();
`ifdef USER_ID_PARITY_EN
        return logic'($countones(model_id()) % 2);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        if (a == 2'd0) return model_id();
        if (a == 2'd1) return m_patch;
        if (a == 2'd2) return 32'(m_lock) + (32'(model_par()) * 2);
        return UPI;
    endfunction

    // Commit the previous cycle's inputs to the model, drive new inputs and
    // queue the outputs expected before the next rising edge.
    task automatic cycle(input logic r, input logic w, input logic [1:0] a,
                         input logic [31:0] d, input logic [1:0] rsel);
        exp_t e;
        @(posedge clk);
        #1;
        if (p_rst) begin
            m_patch = '0;
            m_lock  = 1'b0;
        end else if (p_we) begin
            if (p_wa == 2'd1 && !m_lock) m_patch = p_wd;
            if (p_wa == 2'd2 && p_wd == KEY) m_lock = 1'b1;
        end
        rst = r; we = w; wa = a; wd = d; ra = rsel;
        p_rst = r; p_we = w; p_wa = a; p_wd = d;
        e.kind = 0; e.want = model_id();         q.push_back(e);
        e.kind = 1; e.want = 32'(m_lock);        q.push_back(e);
        e.kind = 2; e.want = model_rd(rsel);     q.push_back(e);
`ifdef USER_ID_PARITY_EN
        e.kind = 3; e.want = 32'(model_par());   q.push_back(e);
`endif
    endtask

    // Monitor: compare every queued expectation at mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] got;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                0:       got = mask_rev;
                1:       got = 32'(locked);
                2:       got = rd_data;
                default: got = 32'(parity);
            endcase
            checks++;
            if (got !== e.want) begin
                errors++;
                $display("FAIL kind%0d ra=%0d got %h want %h at %0t",
                         e.kind, ra, got, e.want, $time);
            end
        end
    end

    initial begin
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
        #10;
        checks++;
        if (mask_rev !== UPI || $isunknown(mask_rev)) begin
            errors++;
            $display("FAIL time0_mask_rev got %h want %h", mask_rev, UPI);
        end
`ifdef USER_ID_PARITY_EN
        checks++;
        if (parity !== 1'b0) begin
            errors++;
            $display("FAIL time0_parity got %b want 0", parity);
        end
`endif

        // Reset for two cycles, then read the ID, BASE and LOCK registers.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 3);
        cycle(0, 0, 0, 0, 2);
        // PATCH write while reading PATCH: pre-edge value is seen.
        cycle(0, 1, 1, 32'h0000_00FF, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 3);
        // Writes to read-only registers are ignored.
        cycle(0, 1, 0, 32'hDEAD_BEEF, 0);
        cycle(0, 1, 3, 32'hDEAD_BEEF, 3);
        // Wrong key, then the right key.
        cycle(0, 1, 2, 32'h1234_5678, 2);
        cycle(0, 0, 0, 0, 2);
        cycle(0, 1, 2, KEY, 2);
        cycle(0, 0, 0, 0, 2);
        // Locked: PATCH write ignored, other lock writes don't clear it.
        cycle(0, 1, 1, 32'hFFFF_FFFF, 0);
        cycle(0, 1, 2, 32'h0000_0000, 1);
        cycle(0, 0, 0, 0, 2);
        // Reset together with a PATCH write: reset wins.
        cycle(1, 1, 1, 32'h5555_AAAA, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 2);
        // Parity flip via single-bit patch; then PATCH then LOCK keeps patch.
        cycle(0, 1, 1, 32'h0000_0001, 2);
        cycle(0, 1, 2, KEY, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 32'h0F0F_0F0F, 1);
        cycle(0, 0, 0, 0, 2);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 7) == 0) ? KEY : $urandom;
            cycle(($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  d,
                  2'($urandom_range(0, 3)));
        end

        cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
